// File: rtl/iterative_alu.sv
// Iterative integer ALU: RV32I base ops with one-cycle registered latency, plus unsigned
// multiply (shift-add) and divide/remainder (restoring) engines behind a valid/ready handshake.
module iterative_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned CntW = SHW + 1;

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpSll   = 4'd2;
  localparam logic [3:0] OpSlt   = 4'd3;
  localparam logic [3:0] OpSltu  = 4'd4;
  localparam logic [3:0] OpXor   = 4'd5;
  localparam logic [3:0] OpSrl   = 4'd6;
  localparam logic [3:0] OpSra   = 4'd7;
  localparam logic [3:0] OpOr    = 4'd8;
  localparam logic [3:0] OpAnd   = 4'd9;
  localparam logic [3:0] OpMul   = 4'd10;
  localparam logic [3:0] OpMulhu = 4'd11;
  localparam logic [3:0] OpDivu  = 4'd12;
  localparam logic [3:0] OpRemu  = 4'd13;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q, overflow_q, negative_q;

  logic                 load;
  logic [WIDTH-1:0]     res_d;
  logic                 ovf_d;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;
  logic [WIDTH-1:0]     add_res, sub_res;
  logic [SHW-1:0]       shamt;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_sub;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;

  // Single-cycle datapath, evaluated on the live inputs at the accepting edge
  always_comb begin
    add_res = A + B;
    sub_res = A - B;
    shamt   = B[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (op)
      OpAdd: begin
        alu_res = add_res;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
      end
      OpSub: begin
        alu_res = sub_res;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
      end
      OpSll:  alu_res = A << shamt;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OpXor:  alu_res = A ^ B;
      OpSrl:  alu_res = A >> shamt;
      OpSra:  alu_res = WIDTH'($signed(A) >>> shamt);
      OpOr:   alu_res = A | B;
      OpAnd:  alu_res = A & B;
      OpDivu: alu_res = '1;  // only reached with B == 0
      OpRemu: alu_res = A;   // only reached with B == 0
      default: alu_res = '0;
    endcase
  end

  // Shift-add multiply step: low half holds the remaining multiplier bits
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + ({1'b0, opnd_q} & {(WIDTH+1){prod_q[0]}});
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  end

  // Restoring divide step: high half is the partial remainder, low half dividend/quotient
  always_comb begin
    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_sub   = div_shift - {1'b0, opnd_q};
    div_next  = {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 prod_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    load    = 1'b0;
    res_d   = '0;
    ovf_d   = 1'b0;
    cnt_inc = cnt_q + CntW'(1);
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = op;
          if (op == OpMul || op == OpMulhu) begin
            prod_d  = {{WIDTH{1'b0}}, B};
            opnd_d  = A;
            cnt_d   = '0;
            state_d = StMul;
          end else if ((op == OpDivu || op == OpRemu) && (B != '0)) begin
            prod_d  = {{WIDTH{1'b0}}, A};
            opnd_d  = B;
            cnt_d   = '0;
            state_d = StDiv;
          end else begin
            load    = 1'b1;
            res_d   = alu_res;
            ovf_d   = alu_ovf;
            state_d = StDone;
          end
        end
      end
      StMul: begin
        prod_d = mul_next;
        cnt_d  = cnt_inc;
        // Final step and result capture share the edge where the counter reaches WIDTH
        if (cnt_inc == CntW'(WIDTH)) begin
          load    = 1'b1;
          res_d   = (op_q == OpMulhu) ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
          state_d = StDone;
        end
      end
      StDiv: begin
        prod_d = div_next;
        cnt_d  = cnt_inc;
        if (cnt_inc == CntW'(WIDTH)) begin
          load    = 1'b1;
          res_d   = (op_q == OpRemu) ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      prod_q     <= '0;
      opnd_q     <= '0;
      op_q       <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      if (load) begin
        result_q   <= res_d;
        zero_q     <= (res_d == '0);
        overflow_q <= ovf_d;
        negative_q <= res_d[WIDTH-1];
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign negative  = negative_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Randomized bench for iterative_alu against a plain-arithmetic reference model.
module tb_iterative_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] A, B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, overflow, negative;

  int n_checks = 0;
  int n_errors = 0;

  iterative_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour straight from the operation table
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic ov, output int lat);
    logic [63:0] p;
    p   = 64'(a) * 64'(b);
    ov  = 1'b0;
    lat = 1;
    case (o)
      4'd0: begin r = a + b; ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'd1: begin r = a - b; ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      4'd2: r = a << (b % W);
      4'd3: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd4: r = (a < b) ? 1 : 0;
      4'd5: r = a ^ b;
      4'd6: r = a >> (b % W);
      4'd7: r = W'($signed(a) >>> (b % W));
      4'd8: r = a | b;
      4'd9: r = a & b;
      4'd10: begin r = p[W-1:0];    lat = W + 1; end
      4'd11: begin r = p[2*W-1:W];  lat = W + 1; end
      4'd12: begin r = (b == 0) ? '1 : a / b; lat = (b == 0) ? 1 : W + 1; end
      4'd13: begin r = (b == 0) ? a : a % b;  lat = (b == 0) ? 1 : W + 1; end
      default: r = '0;
    endcase
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] er;
    logic         eo;
    int           elat, lat;
    model(o, a, b, er, eo, elat);
    check("in_ready_idle", in_ready, 1);
    op = o; A = a; B = b; in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      // Scramble inputs after acceptance; the DUT must have captured them already
      in_valid = 1'b0; A = $urandom; B = $urandom; op = 4'($urandom);
      if (lat == 1) check("in_ready_busy", in_ready, 0);
    end while (!out_valid && lat < 100);
    check("latency", lat, elat);
    check("result", result, er);
    check("zero", zero, (er == 0));
    check("overflow", overflow, eo);
    check("negative", negative, er[W-1]);
    repeat (hold) begin
      in_valid = 1'b1; A = $urandom; B = $urandom;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", result, er);
      check("hold_zero", zero, (er == 0));
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("consume_valid", out_valid, 0);
    check("consume_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0]   o;
    logic [W-1:0] a, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; A = '0; B = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_flags", {zero, overflow, negative}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(4'd7, 32'h8000_0010, 32'h24, 0);
    run_op(4'd3, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(4'd12, 32'd100, 32'd7, 0);
    run_op(4'd13, 32'd100, 32'd7, 0);
    run_op(4'd12, 32'd100, 32'd0, 0);
    run_op(4'd13, 32'd100, 32'd0, 0);
    run_op(4'd1, 32'd5, 32'd5, 5);
    run_op(4'd14, 32'd9, 32'd3, 1);
    run_op(4'd1, 32'h8000_0000, 32'd1, 0);

    // Abort a multiply part way through with an asynchronous reset
    op = 4'd10; A = 32'h1234_5678; B = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_outputs", {result, zero, overflow, negative}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      check("abort_no_output", out_valid, 0);
    end
    run_op(4'd0, 32'd2, 32'd3, 0);

    for (int i = 0; i < 120; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
      if ((o == 4'd12 || o == 4'd13) && $urandom_range(0, 3) == 0) b = '0;
      if ($urandom_range(0, 5) == 0) a = b;
      run_op(o, a, b, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
